// File: rtl/int_wb_arbiter_pkg.sv
// Shared writeback types and requester indices for the integer writeback arbiter.
// Struct widths here must match the XLEN/REG_IDX_W used by int_wb_arbiter.
package int_wb_arbiter_pkg;

  localparam int INT_XLEN       = 32;
  localparam int INT_REG_IDX_W  = 5;
  localparam int INT_WB_NUM_REQ = 3;

  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_MUL = 1;
  localparam int WB_REQ_LSU = 2;

  typedef struct packed {
    logic                     valid;
    logic [INT_REG_IDX_W-1:0] idx;
    logic [INT_XLEN-1:0]      data;
  } int_arch_reg_wb_t;

  typedef struct packed {
    logic                     valid;
    logic [INT_REG_IDX_W-1:0] idx;
    logic [INT_XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/int_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector from ptr upward
// (mod NUM_REQ) and returns a one-hot grant plus the pointer following the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   next_ptr,
  output logic               any_gnt
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] pos;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    any_gnt  = 1'b0;
    sum      = '0;
    pos      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      pos = sum[PTR_W-1:0];
      if (!any_gnt && req[pos]) begin
        gnt[pos] = 1'b1;
        any_gnt  = 1'b1;
        next_ptr = (pos == PTR_W'(NUM_REQ-1)) ? '0 : pos + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Shares the integer register writeback port among NUM_REQ units, each with a 1-entry buffer.
// Optional INT_WB_ARB_BYPASS_EN lets an empty-buffer request win directly (1-cycle latency).
module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = INT_WB_NUM_REQ,
  parameter int XLEN      = INT_XLEN,
  parameter int REG_IDX_W = INT_REG_IDX_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*REG_IDX_W-1:0] i_req_idx,
  input  logic [NUM_REQ*XLEN-1:0]      i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output int_arch_reg_wb_t             o_int_reg_wb,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  wb_req_t             req_in [NUM_REQ];
  wb_req_t             buf_q  [NUM_REQ];
  wb_req_t             win;
  logic [NUM_REQ-1:0]  buf_v;
  logic [NUM_REQ-1:0]  cand;
  logic [NUM_REQ-1:0]  gnt;
  logic [NUM_REQ-1:0]  gnt_buf;
  logic [NUM_REQ-1:0]  accept;
  logic [NUM_REQ-1:0]  load;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_ptr_nxt;
  logic                any_gnt;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_in[k].valid = i_req_valid[k];
      req_in[k].idx   = i_req_idx[k*REG_IDX_W +: REG_IDX_W];
      req_in[k].data  = i_req_data[k*XLEN +: XLEN];
      buf_v[k]        = buf_q[k].valid;
    end
  end

`ifdef INT_WB_ARB_BYPASS_EN
  assign cand = buf_v | i_req_valid;
`else
  assign cand = buf_v;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req      (cand),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .next_ptr (rr_ptr_nxt),
    .any_gnt  (any_gnt)
  );

  assign gnt_buf     = gnt & buf_v;
  assign o_req_ready = ~buf_v | gnt_buf;
  assign accept      = i_req_valid & o_req_ready;
  // A bypass winner goes straight to the output register, so it is never buffered.
  assign load        = accept & ~(gnt & ~buf_v);
  assign o_busy      = |buf_v;

  always_comb begin
    win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        win = buf_v[k] ? buf_q[k] : req_in[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        buf_q[k] <= '0;
      end
      rr_ptr       <= '0;
      o_int_reg_wb <= '0;
      o_grant      <= '0;
    end else if (i_flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        buf_q[k].valid <= 1'b0;
      end
      o_int_reg_wb <= '0;
      o_grant      <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (load[k]) begin
          buf_q[k] <= req_in[k];
        end else if (gnt_buf[k]) begin
          buf_q[k].valid <= 1'b0;
        end
      end
      if (any_gnt) begin
        rr_ptr <= rr_ptr_nxt;
      end
      // x0 results are consumed and granted but never written back.
      o_int_reg_wb.valid <= any_gnt && (win.idx != '0);
      o_int_reg_wb.idx   <= win.idx;
      o_int_reg_wb.data  <= win.data;
      o_grant            <= gnt;
    end
  end

endmodule
